// File: rtl/prco_fetch_seq.sv
// Instruction-sequencing front end for the prco core: owns the PC, runs the fetch
// handshake, pulses decode and waits for write-back retire before fetching again.
module prco_fetch_seq #(
    parameter int                PC_W     = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_step_mode,
    input  logic               i_step,
    output logic               o_mem_req,
    output logic [PC_W-1:0]    o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_data,
    output logic               o_dec_ce,
    output logic [INSTR_W-1:0] o_dec_instr,
    output logic [PC_W-1:0]    o_dec_pc,
    input  logic               i_retire,
    input  logic               i_branch_en,
    input  logic [PC_W-1:0]    i_branch_target,
    input  logic               i_halt,
    output logic               q_halted,
    output logic [PC_W-1:0]    q_pc,
    output logic [CNT_W-1:0]   q_instr_count,
    output logic               q_debug_instr_clk,
    output logic [7:0]         q_debug
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RETIRE,
        S_HALTED
    } state_t;

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc, pc_nx;
    logic               req_nx, ce_nx, halted_nx, dbg_clk_nx;
    logic [PC_W-1:0]    addr_nx, dec_pc_nx;
    logic [INSTR_W-1:0] dec_instr_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               go;

    assign go = i_en && !i_halt && (!i_step_mode || i_step);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nx     = state;
        pc_nx        = pc;
        req_nx       = o_mem_req;
        addr_nx      = o_mem_addr;
        ce_nx        = 1'b0;
        dec_instr_nx = o_dec_instr;
        dec_pc_nx    = o_dec_pc;
        halted_nx    = q_halted;
        cnt_nx       = q_instr_count;
        dbg_clk_nx   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_halt) begin
                    state_nx  = S_HALTED;
                    halted_nx = 1'b1;
                end else if (go) begin
                    state_nx = S_FETCH;
                    req_nx   = 1'b1;
                    addr_nx  = pc;
                end
            end

            S_FETCH: begin
                // Halt and enable are deliberately ignored: a started fetch always completes.
                if (i_mem_ack) begin
                    state_nx     = S_WAIT_RETIRE;
                    dec_instr_nx = i_mem_data;
                    dec_pc_nx    = pc;
                    pc_nx        = pc + PC_W'(1);
                    req_nx       = 1'b0;
                    ce_nx        = 1'b1;
                end
            end

            S_WAIT_RETIRE: begin
                if (i_retire) begin
                    cnt_nx     = q_instr_count + CNT_W'(1);
                    dbg_clk_nx = 1'b1;
                    if (i_branch_en)
                        pc_nx = i_branch_target;

                    if (i_halt) begin
                        state_nx  = S_HALTED;
                        halted_nx = 1'b1;
                    end else if (i_step_mode) begin
                        state_nx = S_IDLE;
                    end else if (i_en) begin
                        state_nx = S_FETCH;
                        req_nx   = 1'b1;
                        addr_nx  = pc_nx;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end

            S_HALTED: begin
                halted_nx = 1'b1;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= S_IDLE;
            pc                <= RESET_PC;
            o_mem_req         <= 1'b0;
            o_mem_addr        <= RESET_PC;
            o_dec_ce          <= 1'b0;
            o_dec_instr       <= '0;
            o_dec_pc          <= '0;
            q_halted          <= 1'b0;
            q_instr_count     <= '0;
            q_debug_instr_clk <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all state updates see pre-edge values.
            state             <= state_nx;
            pc                <= pc_nx;
            o_mem_req         <= req_nx;
            o_mem_addr        <= addr_nx;
            o_dec_ce          <= ce_nx;
            o_dec_instr       <= dec_instr_nx;
            o_dec_pc          <= dec_pc_nx;
            q_halted          <= halted_nx;
            q_instr_count     <= cnt_nx;
            q_debug_instr_clk <= dbg_clk_nx;
        end
    end

    assign q_pc = pc;

    generate
        if (CNT_W >= 8) begin : g_dbg_trunc
            assign q_debug = q_instr_count[7:0];
        end else begin : g_dbg_ext
            assign q_debug = {{(8-CNT_W){1'b0}}, q_instr_count};
        end
    endgenerate

endmodule

// File: doc/prco_fetch_seq.md
Name: prco_fetch_seq

Overview:
- Parametrised instruction-sequencing front end for the prco core family.
- Owns the program counter and a variable-latency fetch handshake to instruction memory.
- Issues one-cycle decode-enable pulses and waits for a retire pulse from write-back before the next fetch.
- Adds over the previous generation: branch redirect, halt, single-step debug mode and an instruction counter.

Parameters:
PC_W, 16, program counter and memory address width
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, retired-instruction counter width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_en  in  1  run enable; sampled only when a new fetch would start
i_step_mode  in  1  1 = single-step: one instruction per i_step pulse
i_step  in  1  step request pulse
o_mem_req  out  1  fetch request, held until ack
o_mem_addr  out  PC_W  fetch address, stable while o_mem_req=1
i_mem_ack  in  1  memory data valid this cycle
i_mem_data  in  INSTR_W  instruction word, valid with i_mem_ack
o_dec_ce  out  1  one-cycle decode enable pulse
o_dec_instr  out  INSTR_W  latched instruction
o_dec_pc  out  PC_W  address of o_dec_instr
i_retire  in  1  write-back complete pulse
i_branch_en  in  1  redirect PC; qualified by i_retire
i_branch_target  in  PC_W  redirect address
i_halt  in  1  halt request
q_halted  out  1  sequencer halted
q_pc  out  PC_W  current PC
q_instr_count  out  CNT_W  retired instruction count
q_debug_instr_clk  out  1  one-cycle pulse per retire
q_debug  out  8  q_instr_count[7:0], zero-extended if CNT_W<8

Behaviour:
- Reset (async, any state, including mid-fetch):
  - pc=RESET_PC, state IDLE.
  - o_mem_req, o_dec_ce, q_halted, q_debug_instr_clk = 0.
  - o_dec_instr, o_dec_pc, q_instr_count = 0; o_mem_addr = RESET_PC.
- All outputs are registered.
- "go" means i_en=1 && !i_halt && (i_step_mode==0 || i_step==1).
- States: IDLE, FETCH, WAIT_RETIRE, HALTED.
- IDLE:
  - i_halt=1 -> HALTED (checked first).
  - Else go=1 -> FETCH, with o_mem_req=1 and o_mem_addr=pc from the next cycle.
  - Else stay.
- FETCH:
  - o_mem_req and o_mem_addr held constant until i_mem_ack.
  - On ack: o_dec_instr<=i_mem_data, o_dec_pc<=pc, pc<=pc+1 (wraps mod 2^PC_W), o_mem_req<=0, -> WAIT_RETIRE.
  - o_dec_ce=1 in exactly the first WAIT_RETIRE cycle.
  - i_halt and i_en are ignored in FETCH; the fetch always completes.
- WAIT_RETIRE:
  - On i_retire (accepted in any cycle, including the o_dec_ce cycle):
    - q_instr_count+1 (wraps); q_debug_instr_clk=1 next cycle, for one cycle.
    - If i_branch_en, pc<=i_branch_target; this overrides the increment already applied.
  - Next state, in priority order:
    - i_halt -> HALTED.
    - i_step_mode=1 -> IDLE.
    - i_en=1 -> FETCH, with req asserted next cycle at the updated pc.
    - Otherwise -> IDLE.
- HALTED: q_halted=1; no requests; exits only via reset.
- Ignored inputs:
  - i_mem_ack outside FETCH.
  - i_retire and i_branch_en outside WAIT_RETIRE.
  - i_branch_en without i_retire.
  - i_step outside IDLE.
- q_pc always shows the current pc register.
- Timing:
  - Zero-wait memory, retire in the o_dec_ce cycle: 2 cycles per instruction.
  - Each memory wait state adds 1 cycle.
  - In single-step mode, exactly one instruction retires per i_step pulse accepted in IDLE.

Test Plan:
- Reset, i_en=1, step_mode=0, zero-wait ack, retire in dec_ce cycle:
  - Req addresses are 0,1,2,3 on every second cycle.
  - o_dec_ce pulses alternate with req.
  - After 4 retires, q_instr_count=4 and q_debug=0x04.
- Ack delayed 3 cycles at addr 5:
  - o_mem_req and o_mem_addr=5 held for 4 cycles.
  - o_dec_instr=data sampled at ack; o_dec_pc=5; exactly one o_dec_ce.
- Retire with i_branch_en=1, target 0x0100 while executing pc 7 -> next req addr 0x0100.
- Branch without retire -> no effect; next addr 8.
- i_step_mode=1:
  - No requests without i_step.
  - Two i_step pulses in IDLE -> exactly two fetches (addr 0,1).
  - An i_step during WAIT_RETIRE is ignored.
- i_halt asserted during FETCH:
  - Fetch completes; the instruction retires.
  - Then q_halted=1 and o_mem_req stays 0 for 20 cycles.
- Async reset mid-fetch:
  - o_mem_req=0 immediately, pc=RESET_PC, count=0.
  - A fetch from RESET_PC resumes after reset release.
- PC_W=4, pc=15: retire without branch -> next fetch addr 0 (wrap).
